snac_input_mapper: RTL
======================

SNAC_INPUT_MAPPER -- requirements
Module: snac_input_mapper

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of player channels (legal 1..4).
REQ-002 SHALL have parameter OUT_W, default 16, width of each mapped player word (legal 10..32).
REQ-003 SHALL have parameter AF_FRAMES, default 4, frames per autofire half-period (legal 1..255).
REQ-004 i_clk  in  1  single clock; all logic on its rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_vsync  in  1  core vertical sync, asynchronous to i_clk, active-high.
REQ-007 i_btn  in  16*NUM_PLAYERS  raw Pocket-layout buttons per player. Bit 0 up, 1 down, 2 left, 3 right, 4..7 A/B/X/Y, 14 select, 15 start. Asynchronous.
REQ-008 i_socd_mode  in  2  opposing-direction policy: 0 passthrough, 1 neutral, 2 last-wins, 3 treated as 1.
REQ-009 i_af_mask  in  4*NUM_PLAYERS  per-player autofire enable for raw bits 7:4.
REQ-010 i_swap  in  1  exchange player 0 and player 1 outputs; quasi-static.
REQ-011 o_player  out  OUT_W*NUM_PLAYERS  mapped Neo Geo words, player 0 in the LSBs.
REQ-012 o_frame  out  1  one-cycle pulse per detected vsync rising edge.

Function
REQ-013 i_btn and i_vsync SHALL each pass through a 2-flop synchroniser before use.
REQ-014 Mapped word bits SHALL be:
- [0] = right (raw 3), [1] = left (raw 2), [2] = down (raw 1), [3] = up (raw 0).
- [7:4] = raw 7:4.
- [8] = start (raw 15), [9] = select (raw 14).
- [OUT_W-1:10] = 0.
REQ-015 o_player SHALL be registered; a steady raw change SHALL appear on o_player exactly 3 cycles after it is applied (2 sync + 1 output), with SOCD and autofire off.
REQ-016 o_frame SHALL pulse on the cycle after the synchronised vsync goes 0->1; a vsync held high SHALL give only one pulse.
REQ-017 SOCD, mode 0: both opposing bits pass unchanged.
REQ-018 SOCD, mode 1: when left and right are both pressed, both SHALL output 0; the same rule applies to up/down.
REQ-019 SOCD, mode 2 (per axis, per player):
- A 1-bit last-pressed register SHALL record whichever opposing bit rose most recently.
- When both are pressed, only the recorded one SHALL output 1.
- If both rise in the same cycle, the axis SHALL output neutral until one is released.
REQ-020 A single frame counter SHALL count o_frame pulses 0..AF_FRAMES-1, wrap to 0, and toggle a global autofire phase bit on each wrap.
REQ-021 A button with its i_af_mask bit set SHALL output (pressed AND phase); unmasked buttons SHALL pass through.
REQ-022 i_swap SHALL be sampled into a swap register only on o_frame cycles. When that register is 1 and NUM_PLAYERS >= 2, channels 0 and 1 SHALL be exchanged at the output. NUM_PLAYERS = 1 SHALL ignore swap.
REQ-023 i_socd_mode and i_af_mask SHALL take effect combinationally on the next output register update, with no frame alignment.
REQ-024 An i_socd_mode change SHALL NOT clear the last-pressed registers.

Reset
REQ-025 While i_rst = 1 (applied asynchronously):
- o_player = 0 and o_frame = 0.
- Synchronisers, last-pressed registers, frame counter and swap register = 0.
- Autofire phase = 1.
REQ-026 Reset asserted mid-frame or mid-autofire SHALL abort all state. After release:
- The first o_frame SHALL require a fresh vsync 0->1 seen through the synchroniser.
- The first output update SHALL occur 3 cycles after release.

Verification
REQ-027 Latency: release reset, NUM_PLAYERS = 2, raw P1 = 0x8011 -> o_player[15:0] = 0x0118 exactly 3 cycles later; P2 word = 0.
REQ-028 SOCD last-wins: mode 2, press left (raw 0x0004), 5 cycles later add right (0x000C) -> word bits[1:0] go from 2'b10 to 2'b01. Release right -> 2'b10. Mode 1 with both held -> 2'b00.
REQ-029 Autofire: AF_FRAMES = 2, mask bit A set, A held, 8 vsync pulses -> mapped bit 4 reads 1,1,0,0,1,1,0,0 per frame. Unmasked B held stays 1.
REQ-030 Swap: P1 = start, P2 = A, i_swap raised mid-frame -> no change until the next o_frame, then channel 0 = 0x0010 and channel 1 = 0x0100.
REQ-031 Reset mid-operation: assert i_rst for 1 cycle during autofire frame 1 -> outputs 0 immediately, frame counter 0, phase 1. Vsync held high across release -> no o_frame until vsync falls and rises again.

Source files
------------

// File: rtl/snac_input_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : snac_input_mapper
//  Description : Maps raw Pocket-layout controller buttons onto Neo Geo player
//                words. Provides input synchronisation, per-axis opposing
//                direction (SOCD) resolution, frame-locked autofire and a
//                frame-aligned player 0/1 swap.
//  Revision    : 1.0 - initial release
// ============================================================================
module snac_input_mapper #(
    parameter int NUM_PLAYERS = 2,
    parameter int OUT_W       = 16,
    parameter int AF_FRAMES   = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_vsync,
    input  logic [16*NUM_PLAYERS-1:0]    i_btn,
    input  logic [1:0]                   i_socd_mode,
    input  logic [4*NUM_PLAYERS-1:0]     i_af_mask,
    input  logic                         i_swap,
    output logic [OUT_W*NUM_PLAYERS-1:0] o_player,
    output logic                         o_frame
);

    localparam int         BTN_W   = 16 * NUM_PLAYERS;
    localparam logic [7:0] AF_LAST = 8'(AF_FRAMES - 1);

    // SOCD policies; any other encoding resolves to neutral
    localparam logic [1:0] SOCD_PASS      = 2'd0;
    localparam logic [1:0] SOCD_LAST_WINS = 2'd2;

    logic [BTN_W-1:0]             btn_meta;
    logic [BTN_W-1:0]             btn_sync;
    logic [4*NUM_PLAYERS-1:0]     dir_prev;

    logic                         vs_meta;
    logic                         vs_sync;
    logic                         vs_prev;
    logic                         vs_valid_0;
    logic                         vs_valid_1;
    logic                         vs_armed;

    logic [7:0]                   frame_cnt;
    logic                         af_phase;
    logic                         swap_q;

    logic [OUT_W*NUM_PLAYERS-1:0] mapped;
    logic [OUT_W*NUM_PLAYERS-1:0] player_next;

    // Resolve one axis. Returns {last_next, tie_next, neg_out, pos_out}.
    // last = 1 means the positive-side button (right/down) rose most recently;
    // tie = both sides rose together and are still both held.
    function automatic logic [3:0] resolve_axis(
        input logic       neg,
        input logic       pos,
        input logic       neg_was,
        input logic       pos_was,
        input logic       last,
        input logic       tie,
        input logic [1:0] mode
    );
        logic rise_n;
        logic rise_p;
        logic last_n;
        logic tie_n;
        logic neg_o;
        logic pos_o;
        rise_n = neg & ~neg_was;
        rise_p = pos & ~pos_was;
        last_n = last;
        tie_n  = tie;
        if (rise_n && rise_p) begin
            tie_n = 1'b1;
        end else if (rise_p) begin
            last_n = 1'b1;
            tie_n  = 1'b0;
        end else if (rise_n) begin
            last_n = 1'b0;
            tie_n  = 1'b0;
        end else if (!(neg && pos)) begin
            tie_n = 1'b0;
        end
        neg_o = neg;
        pos_o = pos;
        if (neg && pos) begin
            if (mode == SOCD_PASS) begin
                neg_o = 1'b1;
                pos_o = 1'b1;
            end else if (mode == SOCD_LAST_WINS && !tie_n) begin
                neg_o = ~last_n;
                pos_o = last_n;
            end else begin
                neg_o = 1'b0;
                pos_o = 1'b0;
            end
        end
        return {last_n, tie_n, neg_o, pos_o};
    endfunction

    // Two-flop button synchroniser plus a copy of the direction bits for rise detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
            dir_prev <= '0;
        end else begin
            btn_meta <= i_btn;
            btn_sync <= btn_meta;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                dir_prev[4*p +: 4] <= btn_sync[16*p +: 4];
            end
        end
    end

    // vsync synchroniser and rising-edge detector; a rise only counts once a
    // genuine low level has been seen since reset, so a vsync held high
    // across reset release does not produce a frame pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vs_meta    <= 1'b0;
            vs_sync    <= 1'b0;
            vs_prev    <= 1'b0;
            vs_valid_0 <= 1'b0;
            vs_valid_1 <= 1'b0;
            vs_armed   <= 1'b0;
            o_frame    <= 1'b0;
        end else begin
            vs_meta    <= i_vsync;
            vs_sync    <= vs_meta;
            vs_prev    <= vs_sync;
            vs_valid_0 <= 1'b1;
            vs_valid_1 <= vs_valid_0;
            vs_armed   <= vs_armed | (vs_valid_1 & ~vs_sync);
            o_frame    <= vs_armed & vs_sync & ~vs_prev;
        end
    end

    // Frame counter with autofire phase toggle on every wrap
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt <= 8'd0;
            af_phase  <= 1'b1;
        end else if (o_frame) begin
            if (frame_cnt == AF_LAST) begin
                frame_cnt <= 8'd0;
                af_phase  <= ~af_phase;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Swap request only takes effect on frame boundaries
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            swap_q <= 1'b0;
        end else if (o_frame) begin
            swap_q <= i_swap;
        end
    end

    generate
        for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
            logic [15:0]      raw;
            logic [3:0]       raw_was;
            logic [3:0]       af_mask;
            logic             last_h;
            logic             tie_h;
            logic             last_v;
            logic             tie_v;
            logic [3:0]       res_h;
            logic [3:0]       res_v;
            logic [OUT_W-1:0] word;
            logic             unused_bits;

            assign raw         = btn_sync[16*p +: 16];
            assign raw_was     = dir_prev[4*p +: 4];
            assign af_mask     = i_af_mask[4*p +: 4];
            assign unused_bits = ^raw[13:8];

            // Horizontal axis: left (raw 2) vs right (raw 3); vertical: up (raw 0) vs down (raw 1)
            always_comb begin
                res_h = resolve_axis(raw[2], raw[3], raw_was[2], raw_was[3],
                                     last_h, tie_h, i_socd_mode);
                res_v = resolve_axis(raw[0], raw[1], raw_was[0], raw_was[1],
                                     last_v, tie_v, i_socd_mode);
            end

            // Last-pressed and tie state per axis, tracked in every SOCD mode
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    last_h <= 1'b0;
                    tie_h  <= 1'b0;
                    last_v <= 1'b0;
                    tie_v  <= 1'b0;
                end else begin
                    last_h <= res_h[3];
                    tie_h  <= res_h[2];
                    last_v <= res_v[3];
                    tie_v  <= res_v[2];
                end
            end

            // Assemble the Neo Geo word; masked face buttons are gated by the autofire phase
            always_comb begin
                word      = '0;
                word[0]   = res_h[0];
                word[1]   = res_h[1];
                word[2]   = res_v[0];
                word[3]   = res_v[1];
                word[7:4] = raw[7:4] & (~af_mask | {4{af_phase}});
                word[8]   = raw[15];
                word[9]   = raw[14];
            end

            assign mapped[OUT_W*p +: OUT_W] = word;
        end

        if (NUM_PLAYERS >= 2) begin : g_swap
            // Exchange channels 0 and 1 when the frame-aligned swap is active
            always_comb begin
                player_next = mapped;
                if (swap_q) begin
                    player_next[OUT_W-1:0]       = mapped[2*OUT_W-1:OUT_W];
                    player_next[2*OUT_W-1:OUT_W] = mapped[OUT_W-1:0];
                end
            end
        end else begin : g_no_swap
            logic unused_swap;
            assign unused_swap = swap_q;
            assign player_next = mapped;
        end
    endgenerate

    // Registered player outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_player <= '0;
        end else begin
            o_player <= player_next;
        end
    end

endmodule
`default_nettype wire
